// File: rtl/v_pkg.sv
`default_nettype none
// ============================================================================
// Module : v_pkg
// Desc   : Shared types for the list-head update pipeline.
// Rev    : 1.0
// ============================================================================
package v_pkg;

  localparam int ID_W        = 8;
  localparam int KEY_W       = 16;
  localparam int SIZE_W      = 16;
  localparam int COUNT_MAX_W = 16;
  localparam int ADDR_W      = 4;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [SIZE_W-1:0] size_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_CLR = 3'd1,
    CMD_ADD = 3'd2,
    CMD_DEL = 3'd3,
    CMD_REP = 3'd4
  } cmd_t;

  // count is sized for the widest supported COUNT_W; only the low COUNT_W bits are live
  typedef struct packed {
    logic                   vld;
    key_t                   key;
    size_t                  size;
    logic [COUNT_MAX_W-1:0] count;
  } state_t;

  typedef struct packed {
    id_t   id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_t;

endpackage
`default_nettype wire

// File: rtl/v_pipe_update_alu.sv
`default_nettype none
// ============================================================================
// Module : v_pipe_update_alu
// Desc   : Combinational next-state, notify and error decision for one list.
// Rev    : 1.0
// ============================================================================
module v_pipe_update_alu
  import v_pkg::*;
#(
  parameter int COUNT_W    = 8,
  parameter int NOTIFY_ALL = 0
) (
  input  cmd_t   i_cmd,
  input  key_t   i_key,
  input  size_t  i_size,
  input  state_t i_old,
  output state_t o_new,
  output logic   o_wen,
  output logic   o_notify,
  output logic   o_err
);

  localparam logic [COUNT_MAX_W-1:0] CNT_MAX = COUNT_MAX_W'((1 << COUNT_W) - 1);
  localparam logic [COUNT_MAX_W-1:0] CNT_ONE = COUNT_MAX_W'(1);

  logic head_chg;

  always_comb begin
    o_new = i_old;
    o_wen = 1'b0;
    o_err = 1'b0;
    case (i_cmd)
      CMD_CLR: begin
        o_new = '0;
        o_wen = 1'b1;
      end
      CMD_ADD: begin
        o_wen = 1'b1;
        if (i_old.count >= CNT_MAX) begin
          o_err = 1'b1;
        end else begin
          o_new.count = i_old.count + CNT_ONE;
        end
        if (!i_old.vld || (i_key < i_old.key)) begin
          o_new.vld  = 1'b1;
          o_new.key  = i_key;
          o_new.size = i_size;
        end
      end
      CMD_DEL: begin
        if (i_old.count == '0) begin
          o_err = 1'b1;
        end else begin
          o_wen       = 1'b1;
          o_new.count = i_old.count - CNT_ONE;
          // An emptied list has no head; zeroed fields keep the notify payload clean
          if (o_new.count == '0) begin
            o_new.vld  = 1'b0;
            o_new.key  = '0;
            o_new.size = '0;
          end
        end
      end
      CMD_REP: begin
        o_wen      = 1'b1;
        o_new.vld  = 1'b1;
        o_new.key  = i_key;
        o_new.size = i_size;
      end
      default: ;
    endcase
    head_chg = (o_new.vld != i_old.vld) || (o_new.key != i_old.key) ||
               (o_new.size != i_old.size);
    o_notify = o_wen && ((NOTIFY_ALL != 0) || head_chg);
  end

endmodule
`default_nettype wire

// File: rtl/v_pipe_update_mc.sv
`default_nettype none
// ============================================================================
// Module : v_pipe_update_mc
// Desc   : 3-stage read-modify-write pipeline keeping per-list head and count.
// Rev    : 1.0
// ============================================================================
module v_pipe_update_mc
  import v_pkg::*;
#(
  parameter int N_LISTS    = 16,
  parameter int COUNT_W    = 8,
  parameter int NOTIFY_ALL = 0,
  localparam int AW        = (N_LISTS > 1) ? $clog2(N_LISTS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_upd_vld,
  input  id_t           i_upd_prod_id,
  input  cmd_t          i_upd_cmd,
  input  key_t          i_upd_key,
  input  size_t         i_upd_size,
  output logic          o_state_ren,
  output logic [AW-1:0] o_state_raddr,
  input  state_t        i_state_rdata,
  output logic          o_state_wen_r,
  output logic [AW-1:0] o_state_waddr_r,
  output state_t        o_state_wdata_r,
  output logic          o_lv0_vld_r,
  output id_t           o_lv0_prod_id_r,
  output key_t          o_lv0_key_r,
  output size_t         o_lv0_size_r,
  output logic          o_err_r
);

  logic          s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q, s2_ok_d, s2_ok_q, s1_ok;
  upd_t          s1_d, s1_q, s2_d, s2_q;
  logic          hold_vld_d, hold_vld_q;
  logic [AW-1:0] hold_addr_d, hold_addr_q, s2_addr, waddr_d, waddr_q;
  state_t        hold_data_d, hold_data_q, old_state, alu_state, wdata_d, wdata_q;
  logic          wen_d, wen_q, lv0_vld_d, lv0_vld_q, err_d, err_q;
  id_t           lv0_id_d, lv0_id_q;
  key_t          lv0_key_d, lv0_key_q;
  size_t         lv0_size_d, lv0_size_q;
  logic          alu_wen, alu_notify, alu_err;

  v_pipe_update_alu #(
    .COUNT_W    (COUNT_W),
    .NOTIFY_ALL (NOTIFY_ALL)
  ) u_alu (
    .i_cmd    (s2_q.cmd),
    .i_key    (s2_q.key),
    .i_size   (s2_q.size),
    .i_old    (old_state),
    .o_new    (alu_state),
    .o_wen    (alu_wen),
    .o_notify (alu_notify),
    .o_err    (alu_err)
  );

  always_comb begin
    s1_vld_d      = i_upd_vld;
    s1_d.id       = i_upd_prod_id;
    s1_d.cmd      = i_upd_cmd;
    s1_d.key      = i_upd_key;
    s1_d.size     = i_upd_size;

    s1_ok         = 32'(s1_q.id) < N_LISTS;
    o_state_ren   = s1_vld_q && s1_ok;
    o_state_raddr = s1_q.id[AW-1:0];
    s2_vld_d      = s1_vld_q;
    s2_ok_d       = s1_ok;
    s2_d          = s1_q;

    // The RAM read misses the two writes still ahead of this command:
    // the one leaving S3 now and the one committed on the read edge itself.
    s2_addr = s2_q.id[AW-1:0];
    if (wen_q && (waddr_q == s2_addr)) begin
      old_state = wdata_q;
    end else if (hold_vld_q && (hold_addr_q == s2_addr)) begin
      old_state = hold_data_q;
    end else begin
      old_state = i_state_rdata;
    end

    wen_d       = s2_vld_q && s2_ok_q && alu_wen;
    lv0_vld_d   = s2_vld_q && s2_ok_q && alu_notify;
    err_d       = s2_vld_q && (!s2_ok_q || alu_err);
    waddr_d     = s2_addr;
    wdata_d     = alu_state;
    lv0_id_d    = s2_q.id;
    lv0_key_d   = alu_state.key;
    lv0_size_d  = alu_state.size;

    hold_vld_d  = wen_q;
    hold_addr_d = waddr_q;
    hold_data_d = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      wen_q      <= 1'b0;
      lv0_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      lv0_id_q   <= '0;
      lv0_key_q  <= '0;
      lv0_size_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      hold_vld_q <= hold_vld_d;
      wen_q      <= wen_d;
      lv0_vld_q  <= lv0_vld_d;
      err_q      <= err_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      lv0_id_q   <= lv0_id_d;
      lv0_key_q  <= lv0_key_d;
      lv0_size_q <= lv0_size_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_q        <= s1_d;
    s2_q        <= s2_d;
    s2_ok_q     <= s2_ok_d;
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
  end

  assign o_state_wen_r   = wen_q;
  assign o_state_waddr_r = waddr_q;
  assign o_state_wdata_r = wdata_q;
  assign o_lv0_vld_r     = lv0_vld_q;
  assign o_lv0_prod_id_r = lv0_id_q;
  assign o_lv0_key_r     = lv0_key_q;
  assign o_lv0_size_r    = lv0_size_q;
  assign o_err_r         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_v_pipe_update_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_v_pipe_update_mc
// Desc   : Directed bench; dut0 uses defaults, dut1 uses COUNT_W=2, NOTIFY_ALL=1.
// Rev    : 1.0
// ============================================================================
module tb_v_pipe_update_mc;
  import v_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   mem_clr;
  logic   upd_vld;
  id_t    upd_id;
  cmd_t   upd_cmd;
  key_t   upd_key;
  size_t  upd_size;

  logic       ren0, wen0, nv0, err0, ren1, wen1, nv1, err1;
  logic [3:0] raddr0, waddr0, raddr1, waddr1;
  state_t     rdata0, wdata0, rdata1, wdata1;
  id_t        nid0, nid1;
  key_t       nk0, nk1;
  size_t      ns0, ns1;

  state_t mem0 [16];
  state_t mem1 [16];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  v_pipe_update_mc dut0 (
    .clk(clk), .rst_n(rst_n), .i_upd_vld(upd_vld), .i_upd_prod_id(upd_id),
    .i_upd_cmd(upd_cmd), .i_upd_key(upd_key), .i_upd_size(upd_size),
    .o_state_ren(ren0), .o_state_raddr(raddr0), .i_state_rdata(rdata0),
    .o_state_wen_r(wen0), .o_state_waddr_r(waddr0), .o_state_wdata_r(wdata0),
    .o_lv0_vld_r(nv0), .o_lv0_prod_id_r(nid0), .o_lv0_key_r(nk0),
    .o_lv0_size_r(ns0), .o_err_r(err0)
  );

  v_pipe_update_mc #(.N_LISTS(16), .COUNT_W(2), .NOTIFY_ALL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_upd_vld(upd_vld), .i_upd_prod_id(upd_id),
    .i_upd_cmd(upd_cmd), .i_upd_key(upd_key), .i_upd_size(upd_size),
    .o_state_ren(ren1), .o_state_raddr(raddr1), .i_state_rdata(rdata1),
    .o_state_wen_r(wen1), .o_state_waddr_r(waddr1), .o_state_wdata_r(wdata1),
    .o_lv0_vld_r(nv1), .o_lv0_prod_id_r(nid1), .o_lv0_key_r(nk1),
    .o_lv0_size_r(ns1), .o_err_r(err1)
  );

  // Synchronous-read RAMs; a read on the write edge returns the old word
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (ren0) rdata0 <= mem0[raddr0];
      if (wen0) mem0[waddr0] <= wdata0;
      if (ren1) rdata1 <= mem1[raddr1];
      if (wen1) mem1[waddr1] <= wdata1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input cmd_t c, input int k, input int s);
    upd_vld  = 1'b1;
    upd_id   = id_t'(id);
    upd_cmd  = c;
    upd_key  = key_t'(k);
    upd_size = size_t'(s);
    tick();
  endtask

  task automatic quiet();
    upd_vld = 1'b0;
    upd_cmd = CMD_NOP;
  endtask

  function automatic state_t st(input bit v, input int k, input int s, input int c);
    state_t r;
    r.vld   = v;
    r.key   = key_t'(k);
    r.size  = size_t'(s);
    r.count = c[COUNT_MAX_W-1:0];
    return r;
  endfunction

  task automatic exp0(input string tag, input bit wen, input int wa, input state_t wd,
                      input bit nv, input int nid, input int nk, input int ns, input bit err);
    check_eq({tag, ".wen"}, 64'(wen0), 64'(wen));
    if (wen) begin
      check_eq({tag, ".waddr"}, 64'(waddr0), 64'(wa));
      check_eq({tag, ".wdata"}, 64'(wdata0), 64'(wd));
    end
    check_eq({tag, ".lv0"}, 64'(nv0), 64'(nv));
    if (nv) begin
      check_eq({tag, ".lv0_id"}, 64'(nid0), 64'(nid));
      check_eq({tag, ".lv0_key"}, 64'(nk0), 64'(nk));
      check_eq({tag, ".lv0_size"}, 64'(ns0), 64'(ns));
    end
    check_eq({tag, ".err"}, 64'(err0), 64'(err));
  endtask

  task automatic exp1(input string tag, input bit wen, input int cnt, input bit nv, input bit err);
    check_eq({tag, ".wen1"}, 64'(wen1), 64'(wen));
    if (wen) check_eq({tag, ".cnt1"}, 64'(wdata1.count), 64'(cnt));
    check_eq({tag, ".lv0_1"}, 64'(nv1), 64'(nv));
    check_eq({tag, ".err1"}, 64'(err1), 64'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    upd_vld = 1'b0; upd_id = '0; upd_cmd = CMD_NOP; upd_key = '0; upd_size = '0;
    repeat (3) tick();
    check_eq("rst.ren", 64'(ren0), 0);
    check_eq("rst.wen", 64'(wen0), 0);
    check_eq("rst.lv0", 64'(nv0), 0);
    check_eq("rst.err", 64'(err0), 0);
    check_eq("rst.waddr", 64'(waddr0), 0);
    check_eq("rst.wdata", 64'(wdata0), 0);
    check_eq("rst.wen1", 64'(wen1), 0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    tick();

    // single ADD on an empty list
    send(3, CMD_ADD, 'h40, 8);
    check_eq("s1.ren", 64'(ren0), 1);
    check_eq("s1.raddr", 64'(raddr0), 3);
    quiet(); tick(); tick();
    exp0("add1", 1, 3, st(1, 'h40, 8, 1), 1, 3, 'h40, 8, 0);

    send(3, CMD_CLR, 0, 0);
    quiet(); tick(); tick();
    exp0("clr", 1, 3, st(0, 0, 0, 0), 1, 3, 0, 0, 0);

    // back-to-back through the S3 bypass
    send(3, CMD_ADD, 'h40, 8);
    send(3, CMD_ADD, 'h20, 5);
    send(3, CMD_ADD, 'h30, 7);
    exp0("b2b1", 1, 3, st(1, 'h40, 8, 1), 1, 3, 'h40, 8, 0);
    quiet(); tick();
    exp0("b2b2", 1, 3, st(1, 'h20, 5, 2), 1, 3, 'h20, 5, 0);
    tick();
    exp0("b2b3", 1, 3, st(1, 'h20, 5, 3), 0, 0, 0, 0, 0);
    tick();
    exp0("idle", 0, 0, st(0, 0, 0, 0), 0, 0, 0, 0, 0);

    // holding-register path (gap of one) then RAM path (gap of two)
    send(5, CMD_ADD, 'h10, 1);
    quiet(); tick();
    send(5, CMD_ADD, 'h08, 2);
    quiet();
    exp0("hold1", 1, 5, st(1, 'h10, 1, 1), 1, 5, 'h10, 1, 0);
    tick(); tick();
    exp0("hold2", 1, 5, st(1, 'h08, 2, 2), 1, 5, 'h08, 2, 0);
    send(5, CMD_ADD, 'h20, 9);
    quiet(); tick(); tick();
    exp0("ram3", 1, 5, st(1, 'h08, 2, 3), 0, 0, 0, 0, 0);

    send(5, CMD_DEL, 0, 0);
    quiet(); tick(); tick();
    exp0("del3", 1, 5, st(1, 'h08, 2, 2), 0, 0, 0, 0, 0);

    // same-head REP: silent with head-change notify, pulses with notify-all
    send(5, CMD_REP, 'h08, 2);
    quiet(); tick(); tick();
    exp0("rep", 1, 5, st(1, 'h08, 2, 2), 0, 0, 0, 0, 0);
    exp1("rep_all", 1, 2, 1, 0);

    send(7, CMD_ADD, 'h55, 3);
    quiet(); tick(); tick();
    exp0("add7", 1, 7, st(1, 'h55, 3, 1), 1, 7, 'h55, 3, 0);
    send(7, CMD_DEL, 0, 0);
    quiet(); tick(); tick();
    exp0("del0", 1, 7, st(0, 0, 0, 0), 1, 7, 0, 0, 0);

    // counter saturation on the 2-bit instance
    send(1, CMD_ADD, 'h10, 1);
    send(1, CMD_ADD, 'h10, 1);
    send(1, CMD_ADD, 'h10, 1);
    exp1("sat1", 1, 1, 1, 0);
    send(1, CMD_ADD, 'h10, 1);
    exp1("sat2", 1, 2, 1, 0);
    quiet(); tick();
    exp1("sat3", 1, 3, 1, 0);
    tick();
    exp1("sat4", 1, 3, 1, 1);
    exp0("nosat4", 1, 1, st(1, 'h10, 1, 4), 0, 0, 0, 0, 0);

    send(2, CMD_DEL, 0, 0);
    quiet(); tick(); tick();
    exp0("delmt", 0, 0, st(0, 0, 0, 0), 0, 0, 0, 0, 1);
    exp1("delmt", 0, 0, 0, 1);

    send(16, CMD_ADD, 1, 1);
    check_eq("badid.ren", 64'(ren0), 0);
    quiet(); tick(); tick();
    exp0("badid", 0, 0, st(0, 0, 0, 0), 0, 0, 0, 0, 1);

    // reset lands while an ADD sits in S1
    send(9, CMD_ADD, 'h77, 4);
    quiet();
    check_eq("pre_rst.ren", 64'(ren0), 1);
    rst_n = 1'b0;
    #1;
    check_eq("in_rst.ren", 64'(ren0), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst.wen", 64'(wen0), 0);
      check_eq("post_rst.lv0", 64'(nv0), 0);
    end
    send(9, CMD_ADD, 'h66, 1);
    quiet(); tick(); tick();
    exp0("after_rst", 1, 9, st(1, 'h66, 1, 1), 1, 9, 'h66, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
